// File: rtl/pimsynth_serial_pkg.sv
// Shared definitions for bit-serial arithmetic blocks: FSM state encoding
// and its width, so later serial units decode states the same way.
package pimsynth_serial_pkg;

   localparam int STATE_W = 2;

   typedef enum logic [STATE_W-1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } serial_state_t;

endpackage

// File: rtl/adder_1bit.sv
// One-bit full adder cell. IMPL_TYPE picks a behavioural sum or an
// explicit gate-level form; both are functionally identical.
module adder_1bit #(
   parameter int IMPL_TYPE = 0
) (
   input  logic a,
   input  logic b,
   input  logic cin,
   output logic sum,
   output logic cout
);

   generate
      if (IMPL_TYPE == 0) begin : g_beh
         // behavioural: let synthesis pick the adder structure
         assign {cout, sum} = {1'b0, a} + {1'b0, b} + {1'b0, cin};
      end else begin : g_gate
         // gate-level: xor sum, majority carry
         assign sum  = a ^ b ^ cin;
         assign cout = (a & b) | (a & cin) | (b & cin);
      end
   endgenerate

endmodule

// File: rtl/sub_int16_serial.sv
// Bit-serial subtractor: Diff = A - B computed LSB first as A + ~B + 1,
// one bit per clock through a single full-adder cell. Handshaked in/out.
module sub_int16_serial
   import pimsynth_serial_pkg::*;
#(
   parameter int WIDTH     = 16,
   parameter int IMPL_TYPE = 0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] Diff,
   output logic             Borrow,
   output logic             Overflow
);

   localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   serial_state_t    state, state_nx;
   logic [WIDTH-1:0] a_q, b_q;
   logic [CNT_W-1:0] cnt;
   logic             carry;
   logic             d, cout;
   logic             last;
   logic             accept;
   logic             c_msb;

   assign last  = (cnt == CNT_W'(WIDTH - 1));
   // carry entering the MSB cell; xor with its carry-out gives signed overflow
   assign c_msb = carry;

   adder_1bit #(.IMPL_TYPE(IMPL_TYPE)) u_cell (
      .a    (a_q[cnt]),
      .b    (~b_q[cnt]),
      .cin  (carry),
      .sum  (d),
      .cout (cout)
   );

   // state register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= ST_IDLE;
      else     state <= state_nx;
   end

   // next-state and handshake outputs
   always_comb begin
      state_nx  = state;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      accept    = 1'b0;
      case (state)
         ST_IDLE: begin
            in_ready = 1'b1;
            if (in_valid) begin
               accept   = 1'b1;
               state_nx = ST_RUN;
            end
         end
         ST_RUN: begin
            if (last) state_nx = ST_DONE;
         end
         ST_DONE: begin
            out_valid = 1'b1;
            if (out_ready) state_nx = ST_IDLE;
         end
         default: state_nx = ST_IDLE;
      endcase
   end

   // operand capture and one bit of subtraction per RUN cycle; results
   // hold until the next RUN overwrites them
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         a_q      <= '0;
         b_q      <= '0;
         cnt      <= '0;
         carry    <= 1'b1;
         Diff     <= '0;
         Borrow   <= 1'b0;
         Overflow <= 1'b0;
      end else if (accept) begin
         a_q   <= A;
         b_q   <= B;
         cnt   <= '0;
         carry <= 1'b1;
      end else if (state == ST_RUN) begin
         Diff[cnt] <= d;
         carry     <= cout;
         if (last) begin
            Borrow   <= ~cout;
            Overflow <= c_msb ^ cout;
         end else begin
            cnt <= cnt + CNT_W'(1);
         end
      end
   end

endmodule

// File: tb/tb_sub_int16_serial.sv
// Directed and random checks of the serial subtractor with a result scoreboard.
module tb_sub_int16_serial;

   localparam int W = 16;

   logic         clk = 1'b0;
   logic         rst;
   logic         in_valid, in_ready, out_valid, out_ready;
   logic [W-1:0] A, B, Diff;
   logic         Borrow, Overflow;

   typedef struct packed {
      logic [W-1:0] diff;
      logic         borrow;
      logic         ovf;
   } exp_t;

   exp_t sb[$];
   int   checks = 0;
   int   fails  = 0;
   int   n_pop  = 0;
   bit   rand_rdy = 1'b0;

   sub_int16_serial #(.WIDTH(W), .IMPL_TYPE(0)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .A         (A),
      .B         (B),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .Diff      (Diff),
      .Borrow    (Borrow),
      .Overflow  (Overflow)
   );

   always #5 clk = ~clk;

   function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b);
      exp_t e;
      e.diff   = a - b;
      e.borrow = (a < b);
      e.ovf    = (a[W-1] != b[W-1]) && (e.diff[W-1] != a[W-1]);
      return e;
   endfunction

   function automatic logic [W-1:0] pick();
      case ($urandom_range(0, 7))
         0:       return 16'h0000;
         1:       return 16'h8000;
         2:       return 16'h7FFF;
         3:       return 16'hFFFF;
         default: return W'($urandom);
      endcase
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // scoreboard: push on accept, pop and compare on delivery, flush on reset
   always @(negedge clk) begin
      exp_t e;
      if (rst) begin
         sb.delete();
      end else begin
         if (out_valid && out_ready) begin
            if (sb.size() == 0) begin
               chk("unexpected_result", 32'd1, 32'd0);
            end else begin
               e = sb.pop_front();
               chk("diff", 32'(Diff), 32'(e.diff));
               chk("borrow", 32'(Borrow), 32'(e.borrow));
               chk("overflow", 32'(Overflow), 32'(e.ovf));
               n_pop++;
            end
         end
         if (in_valid && in_ready) sb.push_back(model(A, B));
      end
   end

   // random consumer back-pressure
   initial forever begin
      @(posedge clk);
      #1;
      if (rand_rdy) out_ready = ($urandom_range(0, 3) != 0);
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic send(input logic [W-1:0] a, input logic [W-1:0] b);
      int n = 0;
      while (!in_ready && n < 200) begin
         @(posedge clk);
         #1;
         n++;
      end
      chk("send_ready_timeout", 32'(n < 200), 32'd1);
      in_valid = 1'b1;
      A = a;
      B = b;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      A = W'($urandom);
      B = W'($urandom);
   endtask

   task automatic wait_valid(output int n);
      n = 0;
      do begin
         @(posedge clk);
         #1;
         n++;
      end while (!out_valid && n < 100);
      chk("valid_timeout", 32'(out_valid), 32'd1);
   endtask

   task automatic op(input logic [W-1:0] a, input logic [W-1:0] b);
      int n;
      send(a, b);
      wait_valid(n);
      @(posedge clk);
      #1;
   endtask

   initial begin
      int  n, p0;
      bit  seen;
      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; A = '0; B = '0;
      #12;
      chk("rst_diff", 32'(Diff), 32'h0);
      chk("rst_borrow", 32'(Borrow), 32'h0);
      chk("rst_ovf", 32'(Overflow), 32'h0);
      chk("rst_out_valid", 32'(out_valid), 32'h0);
      chk("rst_in_ready", 32'(in_ready), 32'h1);
      @(posedge clk); #1; rst = 1'b0;

      // basic subtract plus latency from the accept edge
      send(16'h0005, 16'h0003);
      chk("run_in_ready", 32'(in_ready), 32'h0);
      wait_valid(n);
      chk("latency", 32'(n + 1), 32'd17);
      @(posedge clk); #1;
      chk("idle_in_ready", 32'(in_ready), 32'h1);
      chk("idle_out_valid", 32'(out_valid), 32'h0);
      chk("hold_diff", 32'(Diff), 32'h0002);

      op(16'h0000, 16'h0001);
      op(16'h8000, 16'h0001);
      op(16'h7FFF, 16'hFFFF);

      // stall in DONE while a new request is offered the whole time
      out_ready = 1'b0;
      send(16'h1111, 16'h0101);
      wait_valid(n);
      for (int i = 0; i < 10; i++) begin
         in_valid = 1'b1; A = W'($urandom); B = W'($urandom);
         @(posedge clk); #1;
         chk("stall_out_valid", 32'(out_valid), 32'h1);
         chk("stall_in_ready", 32'(in_ready), 32'h0);
         chk("stall_diff", 32'(Diff), 32'h1010);
      end
      A = 16'h00FF; B = 16'h000F;
      out_ready = 1'b1;
      @(posedge clk); #1;
      chk("release_in_ready", 32'(in_ready), 32'h1);
      chk("release_out_valid", 32'(out_valid), 32'h0);
      @(posedge clk); #1;
      chk("accepted_after_release", 32'(in_ready), 32'h0);
      in_valid = 1'b0;
      wait_valid(n);
      @(posedge clk); #1;

      // abort mid-operation with reset
      send(16'hFFFF, 16'h0001);
      repeat (7) begin @(posedge clk); #1; end
      rst = 1'b1;
      #2;
      chk("abort_out_valid", 32'(out_valid), 32'h0);
      chk("abort_in_ready", 32'(in_ready), 32'h1);
      chk("abort_diff", 32'(Diff), 32'h0);
      @(posedge clk); #1; rst = 1'b0;
      seen = 1'b0;
      repeat (20) begin
         @(posedge clk); #1;
         if (out_valid) seen = 1'b1;
      end
      chk("abort_no_result", 32'(seen), 32'h0);
      op(16'h1234, 16'h0234);
      chk("post_abort_diff", 32'(Diff), 32'h1000);

      // random stream with consumer stalls
      p0 = n_pop;
      rand_rdy = 1'b1;
      for (int i = 0; i < 1000; i++) send(pick(), pick());
      n = 0;
      while (sb.size() != 0 && n < 200) begin @(posedge clk); #1; n++; end
      rand_rdy = 1'b0;
      @(posedge clk); #1;
      out_ready = 1'b1;
      repeat (3) begin @(posedge clk); #1; end
      chk("stream_count", 32'(n_pop - p0), 32'd1000);
      chk("sb_empty", 32'(sb.size()), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

endmodule

// File: doc/sub_int16_serial.md
SUB_INT16_SERIAL -- requirements
Module: sub_int16_serial

Interface
REQ-001 Parameter WIDTH, default 16, operand and result width in bits; legal values are 2 to 64.
REQ-002 Parameter IMPL_TYPE, default 0, selects the implementation of the 1-bit cell; it is passed unchanged to the cell.
REQ-003 Port clk, input, 1 bit, the single clock; all state changes on its rising edge.
REQ-004 Port rst, input, 1 bit, reset; asynchronous, active-high.
REQ-005 Port in_valid, input, 1 bit, A/B hold a request.
REQ-006 Port in_ready, output, 1 bit, the block can accept a request.
REQ-007 Port A, input, WIDTH bits, minuend.
REQ-008 Port B, input, WIDTH bits, subtrahend.
REQ-009 Port out_valid, output, 1 bit, Diff/Borrow/Overflow hold a result.
REQ-010 Port out_ready, input, 1 bit, the consumer accepts the result.
REQ-011 Port Diff, output, WIDTH bits, A minus B, modulo 2^WIDTH.
REQ-012 Port Borrow, output, 1 bit, unsigned borrow (A < B unsigned).
REQ-013 Port Overflow, output, 1 bit, two's-complement signed overflow.

Function
REQ-014 The FSM SHALL have three states: IDLE, RUN and DONE.
REQ-015 IDLE: in_ready=1, out_valid=0; when in_valid=1, latch A and B, clear the bit counter, set the carry register to 1, and go to RUN.
REQ-016 RUN: in_ready=0, out_valid=0; each cycle processes bit i = counter, LSB first.
REQ-017 Per RUN cycle: d = A[i] XOR NOT B[i] XOR c; c' = majority(A[i], NOT B[i], c); Diff[i] SHALL be written with d and the carry updated to c'.
REQ-018 At i = WIDTH-1, save the carry into the MSB cell as c_msb and go to DONE; otherwise increment the counter.
REQ-019 DONE: out_valid=1, in_ready=0; Borrow = NOT final carry; Overflow = c_msb XOR final carry.
REQ-020 DONE with out_ready=1: go to IDLE; Diff, Borrow and Overflow SHALL keep their values until the next RUN writes them.
REQ-021 Latency SHALL be WIDTH+1 cycles from the accept edge to the first out_valid=1 cycle, i.e. 17 for WIDTH=16; throughput SHALL be one result per WIDTH+2 cycles when out_ready=1.
REQ-022 A and B SHALL be sampled only on the accept edge; input changes during RUN or DONE SHALL have no effect.
REQ-023 in_valid=1 in RUN or DONE SHALL be ignored and not queued; no simultaneous accept and deliver; in_ready SHALL return to 1 only in IDLE.
REQ-024 out_ready SHALL be ignored outside DONE; out_valid SHALL stay high with stable outputs while out_ready=0, for any duration.
REQ-025 The counter SHALL be ceil(log2(WIDTH)) bits wide and SHALL never wrap past WIDTH-1.

Reset
REQ-026 While rst=1, asynchronously: state=IDLE, counter=0, carry=1, Diff=0, Borrow=0, Overflow=0, out_valid=0, in_ready=1.
REQ-027 An assertion of rst during RUN or DONE SHALL abort the operation with no result delivered; the first accept after release SHALL behave as from power-up.

Structure
REQ-028 The FSM state enumeration and the state-width constant SHALL live in a shared package (pimsynth_serial_pkg) for reuse by future bit-serial blocks.
REQ-029 The per-bit logic SHALL be one instance of the team's existing adder_1bit cell, fed with NOT B[i] and the carry register, with IMPL_TYPE forwarded; no other sub-modules.

Verification
REQ-030 A=0x0005, B=0x0003 -> after 17 cycles Diff=0x0002, Borrow=0, Overflow=0.
REQ-031 A=0x0000, B=0x0001 -> Diff=0xFFFF, Borrow=1, Overflow=0.
REQ-032 A=0x8000, B=0x0001 -> Diff=0x7FFF, Borrow=0, Overflow=1; then A=0x7FFF, B=0xFFFF -> Diff=0x8000, Borrow=1, Overflow=1.
REQ-033 out_ready held 0 for 10 cycles in DONE, in_valid=1 with new operands throughout -> outputs stable, in_ready=0, no second accept; accept occurs one cycle after out_ready=1.
REQ-034 rst pulsed at RUN bit 7 -> out_valid never rises; next request A=0x1234, B=0x0234 -> Diff=0x1000.
REQ-035 Random back-to-back stream of 1000 pairs with random out_ready stalls -> every result matches the A-B, unsigned-compare and signed-overflow model, with no drops or duplicates.
